dmem_arbiter: RTL

Shares the single data-memory port between the processor core and a host loader/readback path. Requesters hold a request until granted. The arbiter issues one access at a time to the memory, returns read data with a valid pulse, and gives the core strict priority while a matrix run is in progress. It sits between the processor's address/data/write-enable outputs and the data RAM, under the top-level wrapper.

---
 rtl/dmem_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the processor
// core and the host loader/readback path. One access is in flight at a time.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined;
// otherwise the counter ports are tied to zero.
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int WDATA_W      = 24,
    parameter int RDATA_W      = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               core_lock,
    input  logic               core_req,
    input  logic               core_we,
    input  logic [ADDR_W-1:0]  core_addr,
    input  logic [WDATA_W-1:0] core_wdata,
    output logic               core_gnt,
    output logic               core_rvalid,
    output logic [RDATA_W-1:0] core_rdata,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [WDATA_W-1:0] host_wdata,
    output logic               host_gnt,
    output logic               host_rvalid,
    output logic [RDATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_wdata,
    output logic               mem_wren,
    input  logic [RDATA_W-1:0] mem_q,
    output logic               busy,
    output logic [15:0]        core_grant_cnt,
    output logic [15:0]        host_grant_cnt,
    output logic [15:0]        conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RWAIT
    } state_t;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_HOST = 1'b1;
    localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic       owner;
    logic       last_owner;
    logic       cap_we;
    logic [2:0] wait_cnt;
    logic       pick_valid;
    logic       pick_host;
    logic       decide;
    logic       read_done;

    // Arbitration: core_lock locks out the host; otherwise a tie goes to
    // whichever requester was not served last.
    always_comb begin
        pick_valid = 1'b0;
        pick_host  = 1'b0;
        if (core_lock) begin
            pick_valid = core_req;
        end else if (core_req && host_req) begin
            pick_valid = 1'b1;
            pick_host  = (last_owner == OWNER_CORE);
        end else if (core_req) begin
            pick_valid = 1'b1;
        end else if (host_req) begin
            pick_valid = 1'b1;
            pick_host  = 1'b1;
        end
    end

    assign decide    = (state == IDLE) && pick_valid;
    assign read_done = (state == RWAIT) && (wait_cnt == WAIT_LAST);

    // Next-state and strobe outputs; grants and write enable only in ISSUE.
    always_comb begin
        state_next = state;
        core_gnt   = 1'b0;
        host_gnt   = 1'b0;
        mem_wren   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                core_gnt   = (owner == OWNER_CORE);
                host_gnt   = (owner == OWNER_HOST);
                mem_wren   = cap_we;
                state_next = cap_we ? IDLE : RWAIT;
            end
            RWAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winning request; mem_addr/mem_wdata hold between accesses.
    always_ff @(posedge clock) begin
        if (rst) begin
            owner      <= OWNER_CORE;
            last_owner <= OWNER_HOST;
            cap_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (decide) begin
            owner      <= pick_host;
            last_owner <= pick_host;
            cap_we     <= pick_host ? host_we    : core_we;
            mem_addr   <= pick_host ? host_addr  : core_addr;
            mem_wdata  <= pick_host ? host_wdata : core_wdata;
        end
    end

    // Read latency counter, restarted whenever an access is issued.
    always_ff @(posedge clock) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == RWAIT) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    // Return read data to the owner with a single-cycle valid pulse.
    always_ff @(posedge clock) begin
        if (rst) begin
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            core_rdata  <= '0;
            host_rdata  <= '0;
        end else begin
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            if (read_done) begin
                if (owner == OWNER_HOST) begin
                    host_rvalid <= 1'b1;
                    host_rdata  <= mem_q;
                end else begin
                    core_rvalid <= 1'b1;
                    core_rdata  <= mem_q;
                end
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic conflict_event;

    // A decision with host_req high alongside core_req is a conflict,
    // whether the host lost the tie or was held off by core_lock.
    assign conflict_event = decide && core_req && host_req;

    // Saturating statistics counters.
    always_ff @(posedge clock) begin
        if (rst) begin
            core_grant_cnt <= '0;
            host_grant_cnt <= '0;
            conflict_cnt   <= '0;
        end else begin
            if (core_gnt && (core_grant_cnt != 16'hFFFF)) begin
                core_grant_cnt <= core_grant_cnt + 16'd1;
            end
            if (host_gnt && (host_grant_cnt != 16'hFFFF)) begin
                host_grant_cnt <= host_grant_cnt + 16'd1;
            end
            if (conflict_event && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
`else
    assign core_grant_cnt = '0;
    assign host_grant_cnt = '0;
    assign conflict_cnt   = '0;
`endif

endmodule
